onehot_sel_reg: RTL and testbench
=================================

Name: onehot_sel_reg

Overview:
- Parametrised, registered successor to the team's combinational one-hot selectors.
- Selects one of NCH data channels of width W using a one-hot select word, gated by an enable.
- Result is presented through a single-entry valid/ready output register.
- Adds strict/priority decode modes, per-beat error flagging and a saturating error counter.
- Sits between channel sources and downstream consumers that may apply backpressure.

Parameters:
- NCH, 16, number of input channels (>= 2).
- W, 4, data width per channel (>= 1).
- MODE, 0, decode mode: 0 = STRICT (select must be exactly one-hot), 1 = PRIORITY (lowest set bit wins).
- CW, 8, error-counter width (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NCH*W  flattened channels; channel k occupies bits [k*W +: W].
- sel  in  NCH  one-hot channel select.
- enable  in  1  when 0, the accepted beat yields zero data and no error.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  W  registered selected data.
- out_err  out  1  registered error flag for the beat in out_data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the output.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CW  saturating count of accepted error beats.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_data=0, out_err=0, out_valid=0, err_cnt=0. rst_n low mid-transfer drops the held beat immediately. in_ready=1 during and after reset.
- in_ready = !out_valid || out_ready (combinational). This gives full throughput and no combinational path from in_valid to outputs.
- Accept occurs when in_valid && in_ready. On the next edge, out_valid=1 and out_data/out_err are loaded with the decoded result.
- Output drains when out_valid && out_ready. If there is no new accept on the same edge, out_valid goes to 0. If there is, the new beat replaces the old one (back-to-back).
- Stall: while out_valid && !out_ready, out_data and out_err hold. data_in/sel changes are ignored.
- Decode, enable=1, STRICT:
  - popcount(sel)==1 → data of the set index, err=0.
  - popcount(sel)==0 or >=2 → data=0, err=1.
- Decode, enable=1, PRIORITY:
  - Lowest set index wins; multi-hot is not an error.
  - sel==0 → data=0, err=1.
- Decode, enable=0: data=0, err=0, regardless of sel.
- err_cnt:
  - Increments by 1 on each accepted beat whose decoded err=1.
  - Saturates at 2^CW-1; no wrap.
  - err_clr alone → 0.
  - err_clr together with an accepted error beat → 1 (clear then count).
  - Counts at accept, not at drain.
- Latency: 1 cycle from accept to out_valid.
- Width rules: channel index is computed in $clog2(NCH) bits; the select decode is purely combinational before the register.

Decomposition:
- Package onehot_sel_pkg holds:
  - MODE_STRICT=0, MODE_PRIORITY=1.
  - Function for index width, $clog2(NCH).
- Sub-module onehot_sel_decode (combinational), parameterised by NCH and MODE:
  - Input: sel.
  - Outputs: idx, hit (valid select), err.
- Top level contains the mux, the output register, the handshake and err_cnt.

Test Plan:
- Single-channel sweep (NCH=16, W=4, STRICT, enable=1, out_ready=1): data_in channel k = k, sel = 1<<k for k=0..15 → out_data=k one cycle after accept, out_err=0, err_cnt stays 0.
- Strict errors: sel=16'h0000 → out_data=0, out_err=1, err_cnt=1. Then sel=16'h0006 → out_data=0, out_err=1, err_cnt=2. Then sel=16'h0004 → ch2 data, out_err=0, err_cnt=2.
- Priority mode (MODE=1): sel=16'h0006 with ch1=4'hA, ch2=4'h5 → out_data=4'hA, out_err=0. sel=0 → out_err=1.
- Enable gating: enable=0, sel=16'h0003, ch0=4'hF → out_data=0, out_err=0, err_cnt unchanged.
- Backpressure: accept beat A (4'h3), hold out_ready=0 for 3 cycles while driving beat B (4'h7) → in_ready=0 and out_data stays 4'h3. Raise out_ready → A drains, B is accepted the same edge, and out_data=4'h7 next cycle with out_valid continuous.
- Counter boundaries (CW=2): 5 error beats → err_cnt saturates at 3. err_clr on the same cycle as an error accept → err_cnt=1. Assert rst_n=0 mid-stall → out_valid=0, err_cnt=0 immediately.

Source files
------------

// File: rtl/onehot_sel_pkg.sv
// Shared constants and helpers for the registered one-hot selector.
package onehot_sel_pkg;

   localparam int unsigned MODE_STRICT   = 0;
   localparam int unsigned MODE_PRIORITY = 1;

   // Width of a channel index for n channels (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onehot_sel_decode.sv
// Combinational select decoder: lowest set index plus strict/priority validity.
module onehot_sel_decode
   import onehot_sel_pkg::*;
#(
   parameter  int unsigned NCH  = 16,
   parameter  int unsigned MODE = MODE_STRICT,
   localparam int unsigned IW   = idx_width(NCH)
) (
   input  logic [NCH-1:0] sel,
   output logic [IW-1:0]  idx,
   output logic           hit,
   output logic           err
);

   logic any_set;
   logic multi_set;

   // Scan high to low so the last write leaves the lowest set index.
   always_comb begin
      idx       = '0;
      any_set   = 1'b0;
      multi_set = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         multi_set = multi_set | (any_set & sel[i]);
         any_set   = any_set | sel[i];
         if (sel[i]) idx = IW'(i);
      end
      hit = (MODE == MODE_PRIORITY) ? any_set : (any_set & ~multi_set);
      err = ~hit;
   end

endmodule

// File: rtl/onehot_sel_reg.sv
// Registered one-hot channel selector with valid/ready output stage and
// a saturating error counter.
module onehot_sel_reg
   import onehot_sel_pkg::*;
#(
   parameter int unsigned NCH  = 16,
   parameter int unsigned W    = 4,
   parameter int unsigned MODE = MODE_STRICT,
   parameter int unsigned CW   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH*W-1:0] data_in,
   input  logic [NCH-1:0]   sel,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             err_clr,
   output logic [CW-1:0]    err_cnt
);

   localparam int unsigned IW      = idx_width(NCH);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [IW-1:0] dec_idx;
   logic          dec_hit;
   logic          dec_err;
   logic [W-1:0]  beat_data;
   logic          beat_err;
   logic          accept;

   onehot_sel_decode #(
      .NCH  (NCH),
      .MODE (MODE)
   ) u_decode (
      .sel (sel),
      .idx (dec_idx),
      .hit (dec_hit),
      .err (dec_err)
   );

   // Single-entry stage: accept whenever the slot is empty or draining.
   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Channel mux; disabled beats are forced to zero data and no error.
   always_comb begin
      beat_data = '0;
      beat_err  = 1'b0;
      if (enable) begin
         beat_err = dec_err;
         if (dec_hit) begin
            for (int k = 0; k < NCH; k++) begin
               if (dec_idx == IW'(k)) beat_data = data_in[k*W +: W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= beat_data;
         out_err   <= beat_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Clear takes effect first, so a same-cycle error beat lands on one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= (accept & beat_err) ? CW'(1) : '0;
      end else if (accept && beat_err && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_onehot_sel_reg.sv
// Directed bench for onehot_sel_reg: strict, priority and small-counter variants.
module tb_onehot_sel_reg;

   localparam int unsigned NCH = 16;
   localparam int unsigned W   = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NCH*W-1:0] data_in;
   logic [NCH-1:0]   sel;
   logic             enable;
   logic             in_valid;
   logic             out_ready;
   logic             err_clr;

   logic         s_in_ready, s_out_err, s_out_valid;
   logic [W-1:0] s_out_data;
   logic [7:0]   s_err_cnt;
   logic         p_in_ready, p_out_err, p_out_valid;
   logic [W-1:0] p_out_data;
   logic [7:0]   p_err_cnt;
   logic         c_in_ready, c_out_err, c_out_valid;
   logic [W-1:0] c_out_data;
   logic [1:0]   c_err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   onehot_sel_reg #(.NCH(NCH), .W(W), .MODE(0), .CW(8)) u_strict (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .enable(enable),
      .in_valid(in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
      .out_err(s_out_err), .out_valid(s_out_valid), .out_ready(out_ready),
      .err_clr(err_clr), .err_cnt(s_err_cnt)
   );

   onehot_sel_reg #(.NCH(NCH), .W(W), .MODE(1), .CW(8)) u_prio (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .enable(enable),
      .in_valid(in_valid), .in_ready(p_in_ready), .out_data(p_out_data),
      .out_err(p_out_err), .out_valid(p_out_valid), .out_ready(out_ready),
      .err_clr(err_clr), .err_cnt(p_err_cnt)
   );

   onehot_sel_reg #(.NCH(NCH), .W(W), .MODE(0), .CW(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .enable(enable),
      .in_valid(in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
      .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(out_ready),
      .err_clr(err_clr), .err_cnt(c_err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one beat for a single edge; outputs are sampled 1 time unit later.
   task automatic send(input logic [NCH-1:0] s, input logic en);
      sel      = s;
      enable   = en;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      data_in   = '0;
      sel       = '0;
      enable    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      err_clr   = 1'b0;

      #12;
      check("rst_valid", 32'(s_out_valid), 32'd0);
      check("rst_data",  32'(s_out_data),  32'd0);
      check("rst_err",   32'(s_out_err),   32'd0);
      check("rst_cnt",   32'(s_err_cnt),   32'd0);
      check("rst_ready", 32'(s_in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(s_in_ready), 32'd1);

      // Channel k carries value k.
      for (int k = 0; k < 16; k++) data_in[k*W +: W] = 4'(k);
      for (int k = 0; k < 16; k++) begin
         send(NCH'(1) << k, 1'b1);
         check($sformatf("sweep_data%0d", k), 32'(s_out_data), 32'(k));
         check($sformatf("sweep_err%0d", k),  32'(s_out_err),  32'd0);
         check($sformatf("sweep_vld%0d", k),  32'(s_out_valid), 32'd1);
      end
      check("sweep_cnt", 32'(s_err_cnt), 32'd0);
      @(posedge clk);
      #1;
      check("drain_valid", 32'(s_out_valid), 32'd0);

      send(16'h0000, 1'b1);
      check("strict_zero_data", 32'(s_out_data), 32'd0);
      check("strict_zero_err",  32'(s_out_err),  32'd1);
      check("strict_zero_cnt",  32'(s_err_cnt),  32'd1);
      send(16'h0006, 1'b1);
      check("strict_multi_data", 32'(s_out_data), 32'd0);
      check("strict_multi_err",  32'(s_out_err),  32'd1);
      check("strict_multi_cnt",  32'(s_err_cnt),  32'd2);
      check("prio_multi_sweep",  32'(p_out_data), 32'd1);
      send(16'h0004, 1'b1);
      check("strict_ch2_data", 32'(s_out_data), 32'd2);
      check("strict_ch2_err",  32'(s_out_err),  32'd0);
      check("strict_ch2_cnt",  32'(s_err_cnt),  32'd2);

      data_in = '0;
      data_in[1*W +: W] = 4'hA;
      data_in[2*W +: W] = 4'h5;
      send(16'h0006, 1'b1);
      check("prio_data", 32'(p_out_data), 32'hA);
      check("prio_err",  32'(p_out_err),  32'd0);
      check("strict_same_err", 32'(s_out_err), 32'd1);
      send(16'h0000, 1'b1);
      check("prio_zero_err",  32'(p_out_err),  32'd1);
      check("prio_zero_data", 32'(p_out_data), 32'd0);
      check("strict_cnt4",    32'(s_err_cnt),  32'd4);

      data_in = '0;
      data_in[0 +: W] = 4'hF;
      send(16'h0003, 1'b0);
      check("en0_data", 32'(s_out_data), 32'd0);
      check("en0_err",  32'(s_out_err),  32'd0);
      check("en0_cnt",  32'(s_err_cnt),  32'd4);
      check("en0_pdata", 32'(p_out_data), 32'd0);

      // Backpressure: A held while B waits, then B follows on the drain edge.
      data_in[0 +: W] = 4'h3;
      send(16'h0001, 1'b1);
      check("bp_a_data", 32'(s_out_data), 32'h3);
      out_ready = 1'b0;
      data_in[0 +: W] = 4'h7;
      in_valid = 1'b1;
      #1;
      check("bp_ready_low", 32'(s_in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold_data%0d", c), 32'(s_out_data), 32'h3);
         check($sformatf("bp_hold_rdy%0d", c),  32'(s_in_ready), 32'd0);
         check($sformatf("bp_hold_vld%0d", c),  32'(s_out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_ready_high", 32'(s_in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_b_data", 32'(s_out_data),  32'h7);
      check("bp_b_vld",  32'(s_out_valid), 32'd1);
      @(posedge clk);
      #1;
      check("bp_empty", 32'(s_out_valid), 32'd0);

      pulse_reset();
      check("sat_rst_cnt", 32'(c_err_cnt), 32'd0);
      for (int n = 1; n <= 5; n++) begin
         send(16'h0000, 1'b1);
         check($sformatf("sat_cnt%0d", n), 32'(c_err_cnt), 32'((n > 3) ? 3 : n));
      end
      err_clr = 1'b1;
      send(16'h0000, 1'b1);
      err_clr = 1'b0;
      check("clr_with_err", 32'(c_err_cnt), 32'd1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("clr_alone", 32'(c_err_cnt), 32'd0);

      out_ready = 1'b0;
      send(16'h0000, 1'b1);
      check("stall_cnt", 32'(c_err_cnt),   32'd1);
      check("stall_vld", 32'(c_out_valid), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_vld",   32'(c_out_valid), 32'd0);
      check("midrst_cnt",   32'(c_err_cnt),   32'd0);
      check("midrst_ready", 32'(c_in_ready),  32'd1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
